// File: rtl/piso_serializer_if.sv
// Parallel-in / serial-out bus bundle for piso_serializer.
// Handshake: a word moves on a rising clk edge where in_valid && in_ready.
// The producer keeps in_data stable while in_valid=1 and in_ready=0.
// The serial side has no ready: a bit is live whenever ser_valid=1.
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             last_bit;
    logic             busy;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  ser_out,
        input  ser_valid,
        input  last_bit,
        input  busy
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output ser_out,
        output ser_valid,
        output last_bit,
        output busy
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-to-serial converter with a one-word holding register so that
// consecutive words stream with no idle cycle between them.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    piso_serializer_if.slave   bus,
    output logic               o_dbg_state
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] w_sr_nx;
    logic [WIDTH-1:0] r_hr;
    logic [WIDTH-1:0] w_hr_nx;
    logic             r_hr_full;
    logic             w_hr_full_nx;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nx;
    logic [WIDTH-1:0] w_sr_shifted;
    logic             w_xfer;
    logic             w_last;
    logic             w_shift;

    assign w_shift      = (r_state == SHIFT);
    assign w_last       = w_shift && (r_cnt == LAST_CNT);
    assign w_xfer       = bus.in_valid && bus.in_ready;
    // The shift register always moves toward the output end.
    assign w_sr_shifted = MSB_FIRST ? {r_sr[WIDTH-2:0], 1'b0} : {1'b0, r_sr[WIDTH-1:1]};

    assign bus.in_ready  = !r_hr_full && !reset;
    assign bus.ser_valid = w_shift;
    assign bus.ser_out   = w_shift && (MSB_FIRST ? r_sr[WIDTH-1] : r_sr[0]);
    assign bus.last_bit  = w_last;
    assign bus.busy      = w_shift || r_hr_full;
    assign o_dbg_state   = w_shift;

    // Next-state logic: load, shift, refill from HR or input, or go idle.
    always_comb begin
        w_state_nx   = r_state;
        w_sr_nx      = r_sr;
        w_hr_nx      = r_hr;
        w_hr_full_nx = r_hr_full;
        w_cnt_nx     = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    w_sr_nx    = bus.in_data;
                    w_cnt_nx   = '0;
                    w_state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (!w_last) begin
                    w_sr_nx  = w_sr_shifted;
                    w_cnt_nx = r_cnt + CW'(1);
                    if (w_xfer) begin
                        w_hr_nx      = bus.in_data;
                        w_hr_full_nx = 1'b1;
                    end
                end else if (r_hr_full) begin
                    // Queued word follows the current one with no gap.
                    w_sr_nx      = r_hr;
                    w_hr_full_nx = 1'b0;
                    w_cnt_nx     = '0;
                end else if (w_xfer) begin
                    // HR empty: a word offered on the last bit goes straight in.
                    w_sr_nx  = bus.in_data;
                    w_cnt_nx = '0;
                end else begin
                    w_sr_nx    = '0;
                    w_cnt_nx   = '0;
                    w_state_nx = IDLE;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_sr      <= '0;
            r_hr      <= '0;
            r_hr_full <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_sr      <= w_sr_nx;
            r_hr      <= w_hr_nx;
            r_hr_full <= w_hr_full_nx;
            r_cnt     <= w_cnt_nx;
        end
    end
endmodule
